// File: rtl/hr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hr_pkg: shared state encoding and constants for hr_window_ctrl   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package hr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } hr_state_t;

    localparam int unsigned c_MIN_WIN = 2;

endpackage
`default_nettype wire

// File: rtl/hr_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hr_tick_gen: sample-tick prescaler, held at zero while disabled  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hr_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    output logic o_tick
);

    localparam int c_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [c_CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == c_CW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || !i_en) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hr_window_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hr_window_ctrl: sliding-window beat counter driving an external  |
// | FWFT FIFO delay line; prime/run/flush lifecycle. Rev 1.0         |
// +------------------------------------------------------------------+
module hr_window_ctrl
    import hr_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int WIN_W    = 12,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic             i_hb_detect,
    output logic             o_fifo_d,
    output logic             o_fifo_wen,
    output logic             o_fifo_ren,
    input  logic             i_fifo_q,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_full,
    output logic [CNT_W-1:0] o_rate,
    output logic             o_rate_valid,
    input  logic             i_rate_ready,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_err
);

    localparam logic [WIN_W:0] c_RATE_MAX = (WIN_W+1)'((2**CNT_W) - 1);

    hr_state_t        r_state;
    hr_state_t        w_state_next;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] r_fill;
    logic [WIN_W:0]   r_count;
    logic             r_hb_pend;
    logic [CNT_W-1:0] r_rate;
    logic             r_rate_valid;
    logic             r_overrun;
    logic             r_err;

    logic             w_active;
    logic             w_tick;
    logic             w_tick_act;
    logic             w_sample;
    logic [WIN_W-1:0] w_fill_inc;
    logic [WIN_W-1:0] w_win_clamped;
    logic [WIN_W:0]   w_count_next;
    logic [CNT_W-1:0] w_rate_sat;
    logic             w_load_rate;
    logic             w_clear;
    logic             w_err_now;

    assign w_active      = (r_state == ST_PRIME) || (r_state == ST_RUN);
    // A dropped enable wins over a coincident tick: that tick is discarded.
    assign w_tick_act    = w_tick && i_enable;
    assign w_sample      = r_hb_pend | i_hb_detect;
    assign w_fill_inc    = r_fill + WIN_W'(1);
    assign w_win_clamped = (i_win_len < WIN_W'(c_MIN_WIN)) ? WIN_W'(c_MIN_WIN) : i_win_len;
    assign w_count_next  = r_count + (WIN_W+1)'(w_sample)
                         - ((r_state == ST_RUN) ? (WIN_W+1)'(i_fifo_q) : '0);
    assign w_rate_sat    = (w_count_next > c_RATE_MAX) ? CNT_W'(c_RATE_MAX) : CNT_W'(w_count_next);
    assign w_load_rate   = w_tick_act && (r_state == ST_RUN);
    assign w_clear       = (r_state == ST_FLUSH) && i_fifo_empty;
    assign w_err_now     = (o_fifo_wen && i_fifo_full) || (o_fifo_ren && i_fifo_empty);

    hr_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .i_en   (w_active),
        .o_tick (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_fifo_wen   = 1'b0;
        o_fifo_ren   = 1'b0;
        o_fifo_d     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_next = ST_PRIME;
            end
            ST_PRIME: begin
                if (!i_enable) begin
                    w_state_next = ST_FLUSH;
                end else if (w_tick) begin
                    o_fifo_wen = 1'b1;
                    o_fifo_d   = w_sample;
                    if (w_fill_inc == r_win) w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_enable) begin
                    w_state_next = ST_FLUSH;
                end else if (w_tick) begin
                    o_fifo_wen = 1'b1;
                    o_fifo_ren = 1'b1;
                    o_fifo_d   = w_sample;
                end
            end
            ST_FLUSH: begin
                o_fifo_ren = !i_fifo_empty;
                if (i_fifo_empty) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (reset) begin
            o_fifo_wen = 1'b0;
            o_fifo_ren = 1'b0;
            o_fifo_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_win        <= '0;
            r_fill       <= '0;
            r_count      <= '0;
            r_hb_pend    <= 1'b0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_tick_act) begin
                r_hb_pend <= 1'b0;
            end else if (w_active && i_hb_detect) begin
                r_hb_pend <= 1'b1;
            end
            if (w_err_now) r_err <= 1'b1;
            if (r_state == ST_IDLE && i_enable) r_win <= w_win_clamped;
            if (w_load_rate && r_rate_valid && !i_rate_ready) r_overrun <= 1'b1;
            if (w_clear) begin
                r_count      <= '0;
                r_fill       <= '0;
                r_rate       <= '0;
                r_rate_valid <= 1'b0;
            end else begin
                if (w_tick_act) begin
                    r_count <= w_count_next;
                    if (r_state == ST_PRIME) r_fill <= w_fill_inc;
                end
                if (w_load_rate) begin
                    r_rate       <= w_rate_sat;
                    r_rate_valid <= 1'b1;
                end else if (r_rate_valid && i_rate_ready) begin
                    r_rate_valid <= 1'b0;
                end
            end
        end
    end

    assign o_rate       = r_rate;
    assign o_rate_valid = r_rate_valid;
    assign o_overrun    = r_overrun;
    assign o_err        = r_err;
    assign o_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hr_window_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hr_window_ctrl: scoreboard bench with a window-sum reference  |
// | model and an FWFT FIFO model of depth 64. Rev 1.0                |
// +------------------------------------------------------------------+
module tb_hr_window_ctrl;

    localparam int TDIV = 4;
    localparam int WW   = 6;
    localparam int CW   = 4;
    localparam int RMAX = 15;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_FLUSH = 3;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [WW-1:0] win = '0;
    logic          hb = 1'b0;
    logic          ready = 1'b0;
    logic          fifo_d, fifo_wen, fifo_ren, fifo_q, fifo_empty, fifo_full;
    logic [CW-1:0] rate;
    logic          rate_valid, busy, overrun, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    hr_window_ctrl #(
        .TICK_DIV (TDIV),
        .WIN_W    (WW),
        .CNT_W    (CW)
    ) dut (
        .clock        (clock),
        .reset        (rst),
        .i_enable     (en),
        .i_win_len    (win),
        .i_hb_detect  (hb),
        .o_fifo_d     (fifo_d),
        .o_fifo_wen   (fifo_wen),
        .o_fifo_ren   (fifo_ren),
        .i_fifo_q     (fifo_q),
        .i_fifo_empty (fifo_empty),
        .i_fifo_full  (fifo_full),
        .o_rate       (rate),
        .o_rate_valid (rate_valid),
        .i_rate_ready (ready),
        .o_busy       (busy),
        .o_overrun    (overrun),
        .o_err        (err)
    );

    // FWFT FIFO, depth 64
    logic [63:0] mem = '0;
    logic [5:0]  wp = '0, rp = '0;
    logic [6:0]  cnt = '0;
    assign fifo_q     = mem[rp];
    assign fifo_empty = (cnt == 7'd0);
    assign fifo_full  = (cnt == 7'd64);
    always @(posedge clock) begin
        if (rst) begin
            wp <= '0; rp <= '0; cnt <= '0;
        end else begin
            if (fifo_wen && !fifo_full) begin
                mem[wp] <= fifo_d;
                wp <= wp + 6'd1;
            end
            if (fifo_ren && !fifo_empty) rp <= rp + 6'd1;
            cnt <= cnt + 7'(fifo_wen && !fifo_full) - 7'(fifo_ren && !fifo_empty);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the window is a queue of per-tick samples; rate is its clipped sum.
    int m_mode = M_IDLE;
    int m_pre = 0;
    int m_win = 0;
    bit m_pend = 0;
    bit win_q[$];
    int m_rate = 0;
    bit m_valid = 0;
    bit m_ovr = 0;
    int exp_q[$];
    bit e_busy = 0, e_valid = 0, e_ovr = 0, e_wen = 0, e_ren = 0, e_d = 0;
    int e_rate = 0;

    always @(posedge clock) begin
        bit tick, s;
        int sum;
        #2;
        e_busy  = (m_mode != M_IDLE);
        e_valid = m_valid;
        e_rate  = m_rate;
        e_ovr   = m_ovr;
        tick  = (m_mode == M_PRIME || m_mode == M_RUN) && en && (m_pre == TDIV - 1);
        s     = m_pend | hb;
        e_wen = !rst && tick;
        e_ren = !rst && ((tick && m_mode == M_RUN) || (m_mode == M_FLUSH && win_q.size() > 0));
        e_d   = e_wen ? s : 1'b0;
        if (m_valid && ready) exp_q.push_back(m_rate);
        if (rst) begin
            m_mode = M_IDLE; m_pre = 0; m_pend = 0; win_q.delete();
            m_rate = 0; m_valid = 0; m_ovr = 0;
        end else begin
            if (m_valid && ready) m_valid = 0;
            case (m_mode)
                M_IDLE: if (en) begin
                    m_win  = (int'(win) < 2) ? 2 : int'(win);
                    m_pre  = 0;
                    m_mode = M_PRIME;
                end
                M_PRIME, M_RUN: begin
                    if (!en) begin
                        if (hb) m_pend = 1;
                        m_mode = M_FLUSH;
                    end else if (tick) begin
                        m_pre  = 0;
                        m_pend = 0;
                        win_q.push_back(s);
                        if (m_mode == M_RUN) begin
                            void'(win_q.pop_front());
                            sum = 0;
                            foreach (win_q[i]) sum += int'(win_q[i]);
                            if (m_valid) m_ovr = 1;
                            m_rate  = (sum > RMAX) ? RMAX : sum;
                            m_valid = 1;
                        end else if (win_q.size() == m_win) begin
                            m_mode = M_RUN;
                        end
                    end else begin
                        m_pre++;
                        if (hb) m_pend = 1;
                    end
                end
                default: begin
                    if (win_q.size() == 0) begin
                        m_mode = M_IDLE; m_rate = 0; m_valid = 0;
                    end else begin
                        void'(win_q.pop_front());
                    end
                end
            endcase
        end
    end

    // Monitor
    always @(negedge clock) begin
        int e;
        chk("busy", busy, e_busy);
        chk("rate_valid", rate_valid, e_valid);
        chk("rate", rate, e_rate);
        chk("overrun", overrun, e_ovr);
        chk("err", err, 0);
        chk("fifo_wen", fifo_wen, e_wen);
        chk("fifo_ren", fifo_ren, e_ren);
        chk("fifo_d", fifo_d, e_d);
        if (rate_valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("xfer_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_rate", rate, e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) step();
        chk("flush_done", busy, 0);
    endtask

    initial begin
        // Reset with activity on the inputs
        rst = 1; en = 1; hb = 1; ready = 1; win = 6'd5;
        repeat (4) step();
        rst = 0; en = 0; hb = 0;
        step();
        // Window of 4 with beats held
        win = 6'd4; en = 1; hb = 1; ready = 1;
        repeat (40) step();
        // No beats for two ticks, then two pulses inside one tick period
        hb = 0;
        repeat (2 * TDIV) step();
        hb = 1; step(); hb = 0; step(); hb = 1; step(); hb = 0; step();
        repeat (3 * TDIV) step();
        // Held-off consumer across several ticks
        ready = 0; hb = 1;
        repeat (3 * TDIV) step();
        ready = 1;
        repeat (4) step();
        // Drop enable mid-run
        en = 0;
        wait_idle();
        chk("idle_rate", rate, 0);
        // Saturation, then a clamped window
        win = 6'd20; en = 1; hb = 1;
        repeat (32 * TDIV) step();
        en = 0;
        wait_idle();
        win = 6'd0; en = 1;
        for (int c = 0; c < 16 * TDIV; c++) begin
            hb = ($urandom_range(0, 99) < 40);
            step();
        end
        en = 0;
        wait_idle();
        // Randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            win = 6'($urandom_range(0, 40));
            en  = 1;
            for (int c = 0; c < int'($urandom_range(10, 400)); c++) begin
                hb    = ($urandom_range(0, 99) < 30);
                ready = ($urandom_range(0, 99) < 70);
                win   = 6'($urandom_range(0, 63));
                rst   = ($urandom_range(0, 499) == 0);
                step();
            end
            rst = 0; ready = 1;
            en  = 0;
            wait_idle();
        end
        repeat (3) step();
        chk("xfer_leftover", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
